// File: rtl/mmreq_bridge_pkg.sv
// Shared definitions for the mmreq bridge: FSM state encoding, request header
// field positions, the timeout fill word and the response header builder.
package mmreq_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DWAIT = 3'd2,
    ST_DATA  = 3'd3,
    ST_BUS   = 3'd4,
    ST_RESP0 = 3'd5,
    ST_RESP1 = 3'd6
  } state_e;

  // Request header layout: [31] W, [30] unused on input / TO on output,
  // [29:24] tag, [23:0] word address.
  localparam int HDR_W_BIT    = 31;
  localparam int HDR_TO_BIT   = 30;
  localparam int HDR_TAG_MSB  = 29;
  localparam int HDR_TAG_LSB  = 24;
  localparam int HDR_ADDR_MSB = 23;
  localparam int HDR_ADDR_LSB = 0;

  // Data word returned for a read that never saw reg_ack.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // First response word: echo W, tag and the full 24-bit address, with the
  // timeout flag placed where the request carries its ignored bit.
  function automatic logic [31:0] resp_word0(input logic [31:0] hdr,
                                             input logic        to_flag);
    return {hdr[HDR_W_BIT], to_flag,
            hdr[HDR_TAG_MSB:HDR_TAG_LSB],
            hdr[HDR_ADDR_MSB:HDR_ADDR_LSB]};
  endfunction

endpackage

// File: rtl/mmreq_bridge_if.sv
// Signal bundle between the mmreq bridge and its surroundings: the host-to-FPGA
// request FIFO, the FPGA-to-host response FIFO, the register bus and status.
interface mmreq_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);

  // Request FIFO (non-FWFT read side)
  logic                  req_open;
  logic [31:0]           req_dout;
  logic                  req_empty;
  logic                  req_rden;

  // Response FIFO (write side)
  logic [31:0]           resp_din;
  logic                  resp_wren;
  logic                  resp_full;

  // Register bus
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [31:0]           reg_wdata;
  logic                  reg_wr;
  logic                  reg_rd;
  logic [31:0]           reg_rdata;
  logic                  reg_ack;

  // Status
  logic                  busy;
  logic [CNT_WIDTH-1:0]  err_count;

  // Bridge side: drives FIFO strobes, the register bus and status.
  modport master (
    input  req_open, req_dout, req_empty, resp_full, reg_rdata, reg_ack,
    output req_rden, resp_din, resp_wren, reg_addr, reg_wdata, reg_wr, reg_rd,
           busy, err_count
  );

  // Environment side: FIFOs and register targets.
  modport slave (
    output req_open, req_dout, req_empty, resp_full, reg_rdata, reg_ack,
    input  req_rden, resp_din, resp_wren, reg_addr, reg_wdata, reg_wr, reg_rd,
           busy, err_count
  );

endinterface

// File: rtl/mmreq_bridge.sv
// mmreq bridge: pulls peek/poke requests from the host request FIFO, runs each
// one as a single-beat register bus access with a timeout, and pushes a
// two-word response back to the host. One request is in flight at a time.
module mmreq_bridge
  import mmreq_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           bus_clk,
  input  logic           bus_rst,
  mmreq_bridge_if.master bus_if
);

  localparam int                    TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0]     TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0]     TCNT_ZERO = {TCNT_W{1'b0}};
  localparam logic [TCNT_W-1:0]     TCNT_ONE  = TCNT_W'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  ERR_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  ERR_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  ERR_ONE   = CNT_WIDTH'(1'b1);

  state_e                state_q, state_d;
  logic [31:0]           hdr_q, hdr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word1_q, word1_d;
  logic                  to_q, to_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic                  reg_wr_q, reg_rd_q, busy_q;

  logic                  req_rden_s;
  logic                  resp_wren_s;
  logic [31:0]           resp_din_s;
  logic                  hdr_is_wr_s;
  logic                  unused_hdr_s;

  assign hdr_is_wr_s  = hdr_q[HDR_W_BIT];
  // The request's bit 30 carries no meaning; it is latched but never used.
  assign unused_hdr_s = hdr_q[HDR_TO_BIT];

  // Next-state, datapath updates and FIFO handshake strobes.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    wdata_d     = wdata_q;
    word1_d     = word1_q;
    to_d        = to_q;
    tcnt_d      = tcnt_q;
    err_d       = err_q;
    req_rden_s  = 1'b0;
    resp_wren_s = 1'b0;
    resp_din_s  = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        to_d   = 1'b0;
        tcnt_d = TCNT_ZERO;
        if (!bus_if.req_empty) begin
          req_rden_s = 1'b1;
          state_d    = ST_HDR;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_HDR: begin
        // Non-FWFT FIFO: the header is on req_dout the cycle after the strobe.
        hdr_d  = bus_if.req_dout;
        tcnt_d = TCNT_ZERO;
        if (bus_if.req_dout[HDR_W_BIT]) begin
          state_d = ST_DWAIT;
        end else begin
          state_d = ST_BUS;
        end
      end

      ST_DWAIT: begin
        // A closed file abandons a half-delivered write without a response.
        if (!bus_if.req_open) begin
          state_d = ST_IDLE;
        end else if (!bus_if.req_empty) begin
          req_rden_s = 1'b1;
          state_d    = ST_DATA;
        end else begin
          state_d    = ST_DWAIT;
        end
      end

      ST_DATA: begin
        wdata_d = bus_if.req_dout;
        state_d = ST_BUS;
      end

      ST_BUS: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (bus_if.reg_ack) begin
          word1_d = hdr_is_wr_s ? wdata_q : bus_if.reg_rdata;
          state_d = ST_RESP0;
        end else if (tcnt_q == TCNT_LAST) begin
          to_d    = 1'b1;
          word1_d = hdr_is_wr_s ? wdata_q : TIMEOUT_DATA;
          err_d   = (err_q == ERR_MAX) ? err_q : (err_q + ERR_ONE);
          state_d = ST_RESP0;
        end else begin
          tcnt_d  = tcnt_q + TCNT_ONE;
        end
      end

      ST_RESP0: begin
        resp_din_s = resp_word0(hdr_q, to_q);
        if (!bus_if.resp_full) begin
          resp_wren_s = 1'b1;
          state_d     = ST_RESP1;
        end else begin
          state_d     = ST_RESP0;
        end
      end

      ST_RESP1: begin
        resp_din_s = word1_q;
        if (!bus_if.resp_full) begin
          resp_wren_s = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q <= ST_IDLE;
      hdr_q   <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      word1_q <= 32'h0000_0000;
      to_q    <= 1'b0;
      tcnt_q  <= TCNT_ZERO;
      err_q   <= ERR_ZERO;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      wdata_q <= wdata_d;
      word1_q <= word1_d;
      to_q    <= to_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Registered bus strobes and busy flag, looking ahead at the next state so
  // the strobe is up on the first BUS cycle and drops on the cycle after.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      reg_wr_q <= (state_d == ST_BUS) &&  hdr_d[HDR_W_BIT];
      reg_rd_q <= (state_d == ST_BUS) && !hdr_d[HDR_W_BIT];
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // FIFO strobes depend on the live empty/full flags so they can never fire
  // against an empty or full FIFO; reset forces them low immediately.
  assign bus_if.req_rden  = req_rden_s  & ~bus_rst;
  assign bus_if.resp_wren = resp_wren_s & ~bus_rst;
  assign bus_if.resp_din  = bus_rst ? 32'h0000_0000 : resp_din_s;

  assign bus_if.reg_addr  = hdr_q[ADDR_WIDTH-1:0];
  assign bus_if.reg_wdata = wdata_q;
  assign bus_if.reg_wr    = reg_wr_q;
  assign bus_if.reg_rd    = reg_rd_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.err_count = err_q;

endmodule

// File: tb/tb_mmreq_bridge.sv
// Self-checking bench for mmreq_bridge: a request FIFO model, a response
// capture queue checked against an expected-word scoreboard, and a register
// bus responder with a programmable ack delay.
module tb_mmreq_bridge;

  localparam int AW = 16;
  localparam int TO = 16;
  localparam int CW = 16;

  logic bus_clk;
  logic bus_rst;

  mmreq_bridge_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_if ();

  mmreq_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .bus_if  (bus_if)
  );

  // Request FIFO model storage
  logic [31:0] req_mem [0:63];
  int          wr_ptr;
  int          rd_ptr;
  assign bus_if.req_empty = (wr_ptr == rd_ptr);

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // Bus responder and observation state
  int          ack_delay;
  logic        ack_en;
  int          hi_cycles;
  int          last_len;
  logic        seen;
  logic        cap_wr, cap_rd;
  logic [31:0] cap_addr, cap_wdata;
  int          cap_cyc;
  int          first_rden;
  int          cyc;
  int          rden_viol, wren_viol;

  int          chk_cnt;
  int          pass_cnt;

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] w);
    req_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic start_txn();
    first_rden = -1;
    seen       = 1'b0;
    cap_wr     = 1'b0;
    cap_rd     = 1'b0;
    cap_addr   = 32'h0;
    cap_wdata  = 32'h0;
    cap_cyc    = 0;
    last_len   = 0;
  endtask

  // One clock: sample strobes at the falling edge, then apply FIFO/bus effects
  // just after the rising edge.
  task automatic tick();
    logic        s_rden, s_wren, strobe;
    logic [31:0] s_din;
    @(negedge bus_clk);
    s_rden = bus_if.req_rden;
    s_wren = bus_if.resp_wren;
    s_din  = bus_if.resp_din;
    if (s_rden && bus_if.req_empty) rden_viol++;
    if (s_wren && bus_if.resp_full) wren_viol++;
    if (s_rden && first_rden < 0) first_rden = cyc;
    @(posedge bus_clk);
    #1;
    cyc++;
    if (s_rden) begin
      bus_if.req_dout = req_mem[rd_ptr];
      rd_ptr++;
    end
    if (s_wren) got_q.push_back(s_din);
    strobe = bus_if.reg_wr | bus_if.reg_rd;
    if (strobe) begin
      hi_cycles++;
      if (hi_cycles == 1) begin
        seen      = 1'b1;
        cap_wr    = bus_if.reg_wr;
        cap_rd    = bus_if.reg_rd;
        cap_addr  = 32'(bus_if.reg_addr);
        cap_wdata = bus_if.reg_wdata;
        cap_cyc   = cyc;
      end
    end else begin
      if (hi_cycles > 0) last_len = hi_cycles;
      hi_cycles = 0;
    end
    bus_if.reg_ack = ack_en && strobe && (hi_cycles == ack_delay + 1);
  endtask

  // Wait (bounded) for a two-word response and compare it with the scoreboard.
  task automatic wait_resp(input string tag, input int budget);
    int n;
    n = 0;
    while (got_q.size() < 2 && n < budget) begin
      tick();
      n++;
    end
    if (got_q.size() < 2) begin
      check_val({tag, "_resp_count"}, 32'(got_q.size()), 32'd2);
      got_q.delete();
      exp_q.delete();
    end else begin
      check_val({tag, "_word0"}, got_q.pop_front(), exp_q.pop_front());
      check_val({tag, "_word1"}, got_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0; cyc = 0;
    wr_ptr = 0; rd_ptr = 0; rden_viol = 0; wren_viol = 0;
    hi_cycles = 0; ack_en = 1'b1; ack_delay = 0;
    bus_rst = 1'b1;
    bus_if.req_open  = 1'b1;
    bus_if.req_dout  = 32'h0;
    bus_if.resp_full = 1'b0;
    bus_if.reg_rdata = 32'h0;
    bus_if.reg_ack   = 1'b0;
    start_txn();

    // Reset state
    repeat (3) tick();
    check_val("rst_busy",  32'(bus_if.busy), 32'd0);
    check_val("rst_strb",  32'({bus_if.reg_wr, bus_if.reg_rd, bus_if.req_rden, bus_if.resp_wren}), 32'd0);
    check_val("rst_err",   32'(bus_if.err_count), 32'd0);
    check_val("rst_addr",  32'(bus_if.reg_addr), 32'd0);
    check_val("rst_wdata", bus_if.reg_wdata, 32'd0);
    bus_rst = 1'b0;
    repeat (2) tick();

    // 1: write, ack on the 4th strobe cycle
    start_txn(); ack_en = 1'b1; ack_delay = 3;
    push_req(32'h8100_0010); push_req(32'h1234_5678);
    exp_q.push_back(32'h8100_0010); exp_q.push_back(32'h1234_5678);
    wait_resp("t1", 60);
    check_val("t1_kind",  32'({cap_wr, cap_rd}), 32'b10);
    check_val("t1_addr",  cap_addr, 32'h0000_0010);
    check_val("t1_wdata", cap_wdata, 32'h1234_5678);
    check_val("t1_lat",   32'(cap_cyc - first_rden), 32'd4);
    repeat (2) tick();

    // 2: read with data returned on ack
    start_txn(); ack_delay = 1; bus_if.reg_rdata = 32'hCAFE_F00D;
    push_req(32'h0205_00A0);
    exp_q.push_back(32'h0205_00A0); exp_q.push_back(32'hCAFE_F00D);
    wait_resp("t2", 60);
    check_val("t2_kind", 32'({cap_wr, cap_rd}), 32'b01);
    check_val("t2_addr", cap_addr, 32'h0000_00A0);
    check_val("t2_lat",  32'(cap_cyc - first_rden), 32'd2);
    repeat (2) tick();

    // 3: read that never acks -> timeout
    start_txn(); ack_en = 1'b0;
    push_req(32'h0307_0BAD);
    exp_q.push_back(32'h4307_0BAD); exp_q.push_back(32'hDEAD_BEEF);
    wait_resp("t3", 80);
    check_val("t3_len", 32'(last_len), 32'd16);
    check_val("t3_err", 32'(bus_if.err_count), 32'd1);
    repeat (2) tick();

    // 3b: ack on the final allowed cycle is a success
    start_txn(); ack_en = 1'b1; ack_delay = 15; bus_if.reg_rdata = 32'h1357_9BDF;
    push_req(32'h0A0F_0077);
    exp_q.push_back(32'h0A0F_0077); exp_q.push_back(32'h1357_9BDF);
    wait_resp("t3b", 80);
    check_val("t3b_len", 32'(last_len), 32'd16);
    check_val("t3b_err", 32'(bus_if.err_count), 32'd1);
    repeat (2) tick();

    // 4: write header only, host closes the file
    start_txn(); ack_delay = 0;
    push_req(32'h8400_0020);
    repeat (6) tick();
    check_val("t4_wait_busy", 32'(bus_if.busy), 32'd1);
    bus_if.req_open = 1'b0;
    repeat (3) tick();
    check_val("t4_idle",   32'(bus_if.busy), 32'd0);
    check_val("t4_nostrb", 32'(seen), 32'd0);
    check_val("t4_noresp", 32'(got_q.size()), 32'd0);
    bus_if.req_open = 1'b1;
    start_txn(); bus_if.reg_rdata = 32'h55AA_1234;
    push_req(32'h05AB_CDEF);
    exp_q.push_back(32'h05AB_CDEF); exp_q.push_back(32'h55AA_1234);
    wait_resp("t4", 60);
    check_val("t4_addr", cap_addr, 32'h0000_CDEF);
    repeat (2) tick();

    // 5: response FIFO full; bit 30 of the request is ignored
    start_txn(); bus_if.resp_full = 1'b1; bus_if.reg_rdata = 32'h0BAD_CAFE;
    push_req(32'h460B_0040);
    exp_q.push_back(32'h060B_0040); exp_q.push_back(32'h0BAD_CAFE);
    repeat (30) tick();
    check_val("t5_held",  32'(got_q.size()), 32'd0);
    check_val("t5_busy",  32'(bus_if.busy), 32'd1);
    bus_if.resp_full = 1'b0;
    wait_resp("t5", 20);

    // 6: reset while reg_rd is high
    start_txn(); ack_en = 1'b0;
    push_req(32'h070D_0050);
    for (int n = 0; n < 20 && !bus_if.reg_rd; n++) tick();
    check_val("t6_rd_hi", 32'(bus_if.reg_rd), 32'd1);
    push_req(32'h0811_0060);
    exp_q.push_back(32'h0811_0060); exp_q.push_back(32'h7777_8888);
    #2 bus_rst = 1'b1;
    #1;
    check_val("t6_strb",  32'({bus_if.reg_wr, bus_if.reg_rd, bus_if.req_rden, bus_if.resp_wren}), 32'd0);
    check_val("t6_busy",  32'(bus_if.busy), 32'd0);
    check_val("t6_addr",  32'(bus_if.reg_addr), 32'd0);
    check_val("t6_err",   32'(bus_if.err_count), 32'd0);
    check_val("t6_din",   bus_if.resp_din, 32'd0);
    repeat (2) tick();
    bus_rst = 1'b0;
    start_txn(); ack_en = 1'b1; ack_delay = 2; bus_if.reg_rdata = 32'h7777_8888;
    wait_resp("t6", 60);
    check_val("t6_new_addr", cap_addr, 32'h0000_0060);

    check_val("rden_vs_empty", 32'(rden_viol), 32'd0);
    check_val("wren_vs_full",  32'(wren_viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
